// File: rtl/led_light_pkg.sv
// Shared types and defaults for the LED flow controller: mode encodings, FSM states and
// default sizing constants.
package led_light_pkg;

  localparam int unsigned NLedDefault    = 8;
  localparam int unsigned PwmBitsDefault = 4;

  typedef enum logic [1:0] {
    ModeShl      = 2'b00,
    ModeShr      = 2'b01,
    ModePingpong = 2'b10,
    ModeBlink    = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StShl,
    StShr,
    StPingpong,
    StBlink
  } state_e;

  function automatic state_e mode_to_state(input logic [1:0] mode);
    state_e st;
    unique case (mode_e'(mode))
      ModeShl:      st = StShl;
      ModeShr:      st = StShr;
      ModePingpong: st = StPingpong;
      ModeBlink:    st = StBlink;
      default:      st = StIdle;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/led_flow_ctrl_step_sync.sv
// Synchronises the asynchronous step_src level and emits a one-cycle registered strobe per
// rising edge. An edge is only accepted once the input has been seen low after reset.
module step_sync (
  input  logic clk,
  input  logic resetn,
  input  logic step_src,
  output logic step_pulse
);

  logic sync1_q, sync2_q, edge_q;
  logic valid_q, armed_q;
  logic pulse_d, pulse_q;
  logic armed_d;

  // valid_q marks that sync1_q holds a real sample rather than its reset value.
  always_comb begin
    armed_d = armed_q | (valid_q & ~sync1_q);
    pulse_d = armed_q & sync2_q & ~edge_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= step_src;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      valid_q <= 1'b1;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign step_pulse = pulse_q;

endmodule

// File: rtl/led_flow_ctrl.sv
// LED pattern sequencer (shift left/right, ping-pong, blink) advanced by a synchronised step
// input. Optional PWM brightness is enabled by defining LED_PWM_EN.
module led_flow_ctrl
  import led_light_pkg::*;
#(
  parameter int unsigned N_LED    = NLedDefault,
  parameter int unsigned PWM_BITS = PwmBitsDefault
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                step_src,
  input  logic                run,
  input  logic [1:0]          mode,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] duty,
`endif
  output logic [N_LED-1:0]    led,
  output logic                step_pulse
);

  if (N_LED < 2 || PWM_BITS < 1) begin : g_bad_params
    $error("led_flow_ctrl: N_LED must be >= 2 and PWM_BITS >= 1");
  end

  state_e           state_q, state_d;
  logic [N_LED-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] led_mask;

  step_sync u_step_sync (
    .clk        (clk),
    .resetn     (resetn),
    .step_src   (step_src),
    .step_pulse (step_pulse)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    if (!run) begin
      state_d = StIdle;
      pat_d   = '0;
      dir_d   = 1'b0;
    end else if (step_pulse) begin
      // Leaving IDLE and switching mode both restart from the new mode's start pattern.
      if (state_q == StIdle || state_q != mode_to_state(mode)) begin
        state_d = mode_to_state(mode);
        dir_d   = 1'b0;
        unique case (mode_e'(mode))
          ModeShr:   pat_d = {1'b1, {(N_LED-1){1'b0}}};
          ModeBlink: pat_d = '1;
          default:   pat_d = {{(N_LED-1){1'b0}}, 1'b1};
        endcase
      end else begin
        unique case (state_q)
          StShl: pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
          StShr: pat_d = {pat_q[0], pat_q[N_LED-1:1]};
          StPingpong: begin
            if (!dir_q) begin
              if (pat_q[N_LED-1]) begin
                dir_d = 1'b1;
                pat_d = pat_q >> 1;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                dir_d = 1'b0;
                pat_d = pat_q << 1;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          StBlink: pat_d = ~pat_q;
          default: pat_d = pat_q;
        endcase
      end
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    led_mask  = {N_LED{pwm_cnt_q < duty}};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  assign led_mask = '1;
`endif

  assign led_d = pat_d & led_mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      pat_q   <= '0;
      dir_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl: scoreboard of expected LED values per step, checked with
// immediate assertions.
module tb_led_flow_ctrl;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       step_src = 1'b0;
  logic       run      = 1'b0;
  logic [1:0] mode     = 2'b00;
  logic [7:0] led;
  logic       step_pulse;
`ifdef LED_PWM_EN
  logic [3:0] duty     = 4'hF;
`endif

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  logic [7:0] sb_q[$];

  led_flow_ctrl #(
    .N_LED    (8),
    .PWM_BITS (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .step_src   (step_src),
    .run        (run),
    .mode       (mode),
`ifdef LED_PWM_EN
    .duty       (duty),
`endif
    .led        (led),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (step_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // With PWM at full duty the LEDs are dark one cycle in 16; OR two samples to see the pattern.
  task automatic get_led(output logic [7:0] v);
    v = led;
`ifdef LED_PWM_EN
    @(negedge clk);
    v = v | led;
`endif
  endtask

  task automatic run_step(input string tag, input logic [7:0] exp);
    int p0;
    logic [7:0] v;
    sb_q.push_back(exp);
    p0 = pulse_cnt;
    step_src = 1'b1;
    repeat (10) @(negedge clk);
    step_src = 1'b0;
    repeat (10) @(negedge clk);
    check({tag, "_pulses"}, pulse_cnt - p0, 1);
    get_led(v);
    check(tag, {24'h0, v}, {24'h0, sb_q.pop_front()});
  endtask

  initial begin
    logic [7:0] v;
    int p0;
    int hi;

    repeat (3) @(negedge clk);
    check("reset_led", {24'h0, led}, 32'h0);
    check("reset_pulse", {31'h0, step_pulse}, 32'h0);
    resetn = 1'b1;
    run    = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_led", {24'h0, led}, 32'h0);

    // Rotate left with wrap.
    for (int i = 0; i < 9; i++) run_step("shl", 8'h01 << (i % 8));

    // Ping-pong: mode change loads 0x01, then bounces with single-step end bits.
    mode = 2'b10;
    run_step("pp_load", 8'h01);
    for (int i = 1; i < 8; i++) run_step("pp_up", 8'h01 << i);
    for (int i = 6; i >= 0; i--) run_step("pp_down", 8'h01 << i);
    run_step("pp_turn", 8'h02);

    // Mode change between steps must not disturb led.
    mode = 2'b00;
    run_step("shl_load", 8'h01);
    run_step("shl2", 8'h02);
    run_step("shl3", 8'h04);
    run_step("shl4", 8'h08);
    mode = 2'b11;
    repeat (5) @(negedge clk);
    get_led(v);
    check("mode_hold", {24'h0, v}, 32'h08);
    run_step("blink_on", 8'hFF);
    run_step("blink_off", 8'h00);

    // Drop run mid-SHR.
    mode = 2'b01;
    run_step("shr_load", 8'h80);
    run_step("shr2", 8'h40);
    run = 1'b0;
    @(negedge clk);
    check("run_drop", {24'h0, led}, 32'h0);
    run_step("stopped1", 8'h00);
    run_step("stopped2", 8'h00);
    run = 1'b1;
    run_step("shr_restart", 8'h80);
    run_step("shr3", 8'h40);

    // Async reset mid-pattern with step_src held high through release.
    sb_q.push_back(8'h20);
    step_src = 1'b1;
    repeat (10) @(negedge clk);
    get_led(v);
    check("pre_reset", {24'h0, v}, {24'h0, sb_q.pop_front()});
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_reset_led", {24'h0, led}, 32'h0);
    check("async_reset_pulse", {31'h0, step_pulse}, 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    p0 = pulse_cnt;
    repeat (10) @(negedge clk);
    check("no_pulse_high_release", pulse_cnt - p0, 0);
    check("idle_after_reset", {24'h0, led}, 32'h0);
    step_src = 1'b0;
    repeat (10) @(negedge clk);
    run_step("post_reset_shr", 8'h80);

`ifdef LED_PWM_EN
    mode = 2'b00;
    run_step("pwm_load", 8'h01);
    duty = 4'd4;
    @(negedge clk);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (led[0] === 1'b1) hi++;
      @(negedge clk);
    end
    check("pwm_duty4", hi, 4);
    duty = 4'd0;
    @(negedge clk);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (led !== 8'h00) hi++;
      @(negedge clk);
    end
    check("pwm_duty0", hi, 0);
`else
    hi = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_flow_ctrl.md
LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 8, the number of LED outputs (N_LED >= 2).
REQ-002 SHALL have parameter PWM_BITS, default 4, the width of the PWM counter and duty input.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all flops on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port step_src, input, 1 bit: the divided clock_div.clk_sys output, treated as an asynchronous level and never used as a clock.
REQ-006 SHALL have port run, input, 1 bit: enables the pattern.
REQ-007 SHALL have port mode, input, 2 bits: 00 SHL, 01 SHR, 10 PINGPONG, 11 BLINK.
REQ-008 SHALL have port duty, input, PWM_BITS bits: brightness, present only with LED_PWM_EN.
REQ-009 SHALL have port led, output, N_LED bits: the LED drive, registered.
REQ-010 SHALL have port step_pulse, output, 1 bit: the internal step strobe, for debug and bench use.

Function
REQ-011 SHALL synchronise step_src through 2 flops, then detect the rising edge with a third flop; step_pulse SHALL be high for exactly 1 clk cycle per step_src rising edge.
REQ-012 A step_src rise sampled at clk edge k SHALL assert step_pulse after edge k+2; step_src falling edges SHALL produce no pulse.
REQ-013 SHALL implement the FSM states IDLE, SHL, SHR, PINGPONG and BLINK; the pattern register SHALL be N_LED bits wide, plus a direction bit dir (0 = up).
REQ-014 In IDLE, the block SHALL hold led = 0 and ignore mode.
REQ-015 IDLE -> state(mode) SHALL occur on the first step_pulse with run=1, loading the start pattern in the same cycle: SHL/PINGPONG bit0 only (dir=0), SHR bit N_LED-1 only, BLINK all ones.
REQ-016 Any state -> IDLE SHALL occur on the clk edge after run is sampled 0, independent of step_pulse; the pattern SHALL be cleared.
REQ-017 SHL SHALL rotate left by 1 per step, with wrap: bit N_LED-1 goes to bit0.
REQ-018 SHR SHALL rotate right by 1 per step, with wrap: bit0 goes to bit N_LED-1.
REQ-019 PINGPONG SHALL shift toward the end given by dir; on reaching bit N_LED-1 (dir=0) or bit0 (dir=1), the next step SHALL reverse dir and move away, so each end bit is lit for exactly one step and the pattern never stalls.
REQ-020 BLINK SHALL invert the pattern every step (all ones, all zeros, ...).
REQ-021 A mode change while running SHALL take effect only at the next step_pulse: the state switches and the new mode's start pattern loads; mode changes between steps SHALL not disturb led.
REQ-022 With run=1 and mode unchanged, the pattern SHALL advance only on step_pulse cycles and otherwise hold.
REQ-023 led SHALL update one clk cycle after the step_pulse cycle; without LED_PWM_EN, led SHALL equal the pattern.

Reset
REQ-024 While resetn=0, the block SHALL force state=IDLE, pattern=0, dir=0, sync/edge flops=0, step_pulse=0, led=0 and the PWM counter=0.
REQ-025 Reset asserted mid-pattern SHALL clear the outputs immediately (asynchronously).
REQ-026 After deassertion, the block SHALL require a fresh step_src rising edge before leaving IDLE; a step_src already high at release SHALL produce no pulse until it falls and rises again.

Configuration
REQ-027 The macro LED_PWM_EN defined SHALL add the duty port and a free-running PWM_BITS counter (wrapping at 2^PWM_BITS-1 -> 0), with led = pattern AND (pwm_cnt < duty), registered.
REQ-028 Under LED_PWM_EN, duty=0 SHALL give fully dark and duty=2^PWM_BITS-1 SHALL give on for (2^PWM_BITS-1) of 2^PWM_BITS cycles; a duty change SHALL take effect on the next clk.
REQ-029 Without LED_PWM_EN, there SHALL be no duty port and no PWM counter, and led = pattern.

Structure
REQ-030 Package led_light_pkg SHALL hold the mode encodings, the FSM state enum and the default N_LED/PWM_BITS constants.
REQ-031 Sub-module step_sync SHALL contain the 2-flop synchroniser and the edge detector, and output step_pulse.

Verification
REQ-032 Bench SHALL cover: clk 100 MHz, step_src period 200 ns, run=1, mode=00, N_LED=8 -> led 0x01, 0x02, ..., 0x80, 0x01 on successive steps; one step_pulse per step_src period.
REQ-033 Bench SHALL cover: mode=10 -> led 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01, 0x02; 0x80 and 0x01 each held for one step only.
REQ-034 Bench SHALL cover: mode 00 -> 11 applied between steps at led=0x08 -> led stays 0x08 until the next step, then 0xFF, then 0x00.
REQ-035 Bench SHALL cover: run dropped mid-SHR -> led=0x00 one clk later despite further step_src edges; run raised again -> SHR restarts at 0x80 on the next step.
REQ-036 Bench SHALL cover: resetn pulsed low mid-pattern -> led=0 asynchronously; with step_src held high at release, no step_pulse until the next rising edge.
REQ-037 Bench SHALL cover: with LED_PWM_EN, duty=4, pattern 0x01 -> led[0] high for 4 of every 16 clk cycles; duty=0 -> led=0 throughout.
